sram_arbiter: RTL and testbench

- Sequences the single shared base SRAM between the instruction-fetch port and the data port. Both ports present physical word addresses, with the data port also carrying a ramOp and byte offset, after MMU translation.
- Provides multi-cycle SRAM timing, byte-lane enables, load sign/zero extension and per-port stall signals to the pipeline.
- Sits between the MMU physical-address outputs and the board SRAM pins. UART and VGA traffic never reach this block.

---
 rtl/sram_arbiter_pkg.sv | 59 +++++
 rtl/sram_arbiter_if.sv | 37 +++
 rtl/sram_arbiter_load_extend.sv | 37 +++
 rtl/sram_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared memory-op codes, arbiter state encoding and byte-lane helpers for
// the base SRAM arbiter and anything else that speaks MEM_* ops.
package sram_arbiter_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LW  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LHU = 4'd3;
  localparam logic [3:0] MEM_LB  = 4'd4;
  localparam logic [3:0] MEM_LBU = 4'd5;
  localparam logic [3:0] MEM_SW  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SB  = 4'd8;

  // Active-low lane enables: bit n low enables byte lane n.
  localparam logic [3:0] BE_ALL     = 4'b0000;
  localparam logic [3:0] BE_LO_HALF = 4'b1100;
  localparam logic [3:0] BE_HI_HALF = 4'b0011;
  localparam logic [3:0] BE_NONE    = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } arb_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {MEM_SW, MEM_SH, MEM_SB};
  endfunction

  function automatic logic is_data_op(input logic [3:0] op);
    return is_load(op) | is_store(op);
  endfunction

  function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] bytes);
    case (op)
      MEM_SH:  return bytes[1] ? BE_HI_HALF : BE_LO_HALF;
      MEM_SB:  return ~(4'b0001 << bytes);
      default: return BE_ALL;
    endcase
  endfunction

  // Narrow stores are replicated so the enabled lane always carries the data.
  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wdata);
    case (op)
      MEM_SH:  return {2{wdata[15:0]}};
      MEM_SB:  return {4{wdata[7:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Pipeline-side fetch/data ports and board SRAM pins of the arbiter.
interface sram_arbiter_if #(parameter int ADDR_W = 20);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_rdata;
  logic              inst_done;
  logic              inst_stall;

  logic [3:0]        data_op;
  logic [ADDR_W-1:0] data_addr;
  logic [1:0]        data_bytes;
  logic [31:0]       data_wdata;
  logic [31:0]       data_rdata;
  logic              data_done;
  logic              data_stall;

  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_dq_o;
  logic [31:0]       sram_dq_i;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [3:0]        sram_be_n;

  modport slave (
    input  inst_req, inst_addr, data_op, data_addr, data_bytes, data_wdata, sram_dq_i,
    output inst_rdata, inst_done, inst_stall, data_rdata, data_done, data_stall,
           sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

  modport master (
    output inst_req, inst_addr, data_op, data_addr, data_bytes, data_wdata, sram_dq_i,
    input  inst_rdata, inst_done, inst_stall, data_rdata, data_done, data_stall,
           sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );
endinterface

// File: rtl/sram_arbiter_load_extend.sv
// Load lane select and sign/zero extension keyed on MEM_* op and byte offset;
// purely combinational so other load paths can reuse it.
module load_extend
  import sram_arbiter_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_bytes,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = i_word[8*gi +: 8];
    end
  endgenerate

  assign w_byte = w_lane[i_bytes];
  assign w_half = i_bytes[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_op)
      MEM_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_data = {24'h0, w_byte};
      MEM_LH:  o_data = {{16{w_half[15]}}, w_half};
      MEM_LHU: o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the base SRAM between instruction fetch and data accesses, with
// data priority bounded by a fetch starvation limit and fully registered pins.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int READ_WAIT  = 1,
  parameter int WE_PULSE   = 2,
  parameter int STARVE_MAX = 2
)
(
  input  logic            clk,
  input  logic            rst,
  sram_arbiter_if.slave   bus
);

  arb_state_e        r_state, w_state_next;
  logic [2:0]        r_cnt, w_cnt_next;
  logic [3:0]        r_starve, w_starve_next;
  logic              r_owner_data, w_owner_data_next;
  logic [3:0]        r_op, w_op_next;
  logic [1:0]        r_bytes, w_bytes_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [31:0]       r_dq_o, w_dq_o_next;
  logic              r_dq_oe, w_dq_oe_next;
  logic              r_ce_n, w_ce_n_next;
  logic              r_oe_n, w_oe_n_next;
  logic              r_we_n, w_we_n_next;
  logic [3:0]        r_be_n, w_be_n_next;
  logic [31:0]       r_inst_rdata, w_inst_rdata_next;
  logic [31:0]       r_data_rdata, w_data_rdata_next;
  logic              r_inst_done, w_inst_done_next;
  logic              r_data_done, w_data_done_next;

  logic              w_data_req;
  logic              w_grant_inst;
  logic              w_grant_data;
  logic [31:0]       w_load_word;

  assign w_data_req   = is_data_op(bus.data_op);
  assign w_grant_inst = (r_state == ST_IDLE) && bus.inst_req &&
                        (!w_data_req || (r_starve == 4'(STARVE_MAX)));
  assign w_grant_data = (r_state == ST_IDLE) && w_data_req && !w_grant_inst;

  load_extend u_load_extend (
    .i_op    (r_op),
    .i_bytes (r_bytes),
    .i_word  (bus.sram_dq_i),
    .o_data  (w_load_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_starve     <= '0;
      r_owner_data <= 1'b0;
      r_op         <= MEM_NOP;
      r_bytes      <= '0;
      r_addr       <= '0;
      r_dq_o       <= '0;
      r_dq_oe      <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_be_n       <= BE_NONE;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_starve     <= w_starve_next;
      r_owner_data <= w_owner_data_next;
      r_op         <= w_op_next;
      r_bytes      <= w_bytes_next;
      r_addr       <= w_addr_next;
      r_dq_o       <= w_dq_o_next;
      r_dq_oe      <= w_dq_oe_next;
      r_ce_n       <= w_ce_n_next;
      r_oe_n       <= w_oe_n_next;
      r_we_n       <= w_we_n_next;
      r_be_n       <= w_be_n_next;
      r_inst_rdata <= w_inst_rdata_next;
      r_data_rdata <= w_data_rdata_next;
      r_inst_done  <= w_inst_done_next;
      r_data_done  <= w_data_done_next;
    end
  end

  // Starvation only accumulates while a fetch is actually waiting.
  always_comb begin
    w_starve_next = r_starve;
    if (!bus.inst_req || w_grant_inst) begin
      w_starve_next = '0;
    end else if (w_grant_data) begin
      w_starve_next = r_starve + 4'd1;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_owner_data_next = r_owner_data;
    w_op_next         = r_op;
    w_bytes_next      = r_bytes;
    w_addr_next       = r_addr;
    w_dq_o_next       = r_dq_o;
    w_dq_oe_next      = r_dq_oe;
    w_ce_n_next       = r_ce_n;
    w_oe_n_next       = r_oe_n;
    w_we_n_next       = r_we_n;
    w_be_n_next       = r_be_n;
    w_inst_rdata_next = r_inst_rdata;
    w_data_rdata_next = r_data_rdata;
    w_inst_done_next  = 1'b0;
    w_data_done_next  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_grant_inst) begin
          w_state_next      = ST_RD;
          w_owner_data_next = 1'b0;
          w_op_next         = MEM_LW;
          w_bytes_next      = 2'b00;
          w_addr_next       = bus.inst_addr;
          w_cnt_next        = '0;
          w_ce_n_next       = 1'b0;
          w_oe_n_next       = 1'b0;
          w_be_n_next       = BE_ALL;
        end else if (w_grant_data) begin
          w_owner_data_next = 1'b1;
          w_op_next         = bus.data_op;
          w_bytes_next      = bus.data_bytes;
          w_addr_next       = bus.data_addr;
          w_cnt_next        = '0;
          w_ce_n_next       = 1'b0;
          if (is_store(bus.data_op)) begin
            w_state_next = ST_WR_SETUP;
            w_dq_oe_next = 1'b1;
            w_we_n_next  = 1'b1;
            w_be_n_next  = store_be(bus.data_op, bus.data_bytes);
            w_dq_o_next  = store_data(bus.data_op, bus.data_wdata);
          end else begin
            w_state_next = ST_RD;
            w_oe_n_next  = 1'b0;
            w_be_n_next  = BE_ALL;
          end
        end
      end

      ST_RD: begin
        if (r_cnt == 3'(READ_WAIT)) begin
          w_state_next = ST_DONE;
          w_ce_n_next  = 1'b1;
          w_oe_n_next  = 1'b1;
          w_be_n_next  = BE_NONE;
          if (r_owner_data) begin
            w_data_rdata_next = w_load_word;
            w_data_done_next  = 1'b1;
          end else begin
            w_inst_rdata_next = bus.sram_dq_i;
            w_inst_done_next  = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 3'd1;
        end
      end

      ST_WR_SETUP: begin
        w_state_next = ST_WR_PULSE;
        w_we_n_next  = 1'b0;
        w_cnt_next   = '0;
      end

      ST_WR_PULSE: begin
        if (r_cnt == 3'(WE_PULSE - 1)) begin
          w_state_next = ST_WR_HOLD;
          w_we_n_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 3'd1;
        end
      end

      // Data stays driven through the hold cycle to cover SRAM data-hold time.
      ST_WR_HOLD: begin
        w_state_next     = ST_DONE;
        w_ce_n_next      = 1'b1;
        w_dq_oe_next     = 1'b0;
        w_be_n_next      = BE_NONE;
        w_data_done_next = 1'b1;
      end

      ST_DONE: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.inst_rdata = r_inst_rdata;
  assign bus.inst_done  = r_inst_done;
  assign bus.inst_stall = bus.inst_req & ~r_inst_done;
  assign bus.data_rdata = r_data_rdata;
  assign bus.data_done  = r_data_done;
  assign bus.data_stall = w_data_req & ~r_data_done;
  assign bus.sram_addr  = r_addr;
  assign bus.sram_dq_o  = r_dq_o;
  assign bus.sram_dq_oe = r_dq_oe;
  assign bus.sram_ce_n  = r_ce_n;
  assign bus.sram_oe_n  = r_oe_n;
  assign bus.sram_we_n  = r_we_n;
  assign bus.sram_be_n  = r_be_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench: two arbiter builds against behavioural SRAM models and
// a reference memory/extension model written from the access rules.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW  = 20;
  localparam int RW0 = 1;
  localparam int WE0 = 2;
  localparam int RW1 = 0;
  localparam int WE1 = 1;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW)) bus0 ();
  sram_arbiter_if #(.ADDR_W(AW)) bus1 ();

  sram_arbiter #(.ADDR_W(AW)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sram_arbiter #(.ADDR_W(AW), .READ_WAIT(RW1), .WE_PULSE(WE1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] ref0 [256];

  function automatic logic [31:0] init_word(input int k);
    if (k == 16) return 32'h24020005;
    if (k == 48) return 32'h80FF1234;
    return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Asynchronous-read SRAM models; writes land on lanes enabled while we_n is low.
  assign bus0.sram_dq_i = (!bus0.sram_ce_n && !bus0.sram_oe_n) ? mem0[bus0.sram_addr[7:0]] : 32'hDEADBEEF;
  assign bus1.sram_dq_i = (!bus1.sram_ce_n && !bus1.sram_oe_n) ? mem1[bus1.sram_addr[7:0]] : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) begin
        mem0[k] <= init_word(k);
        mem1[k] <= init_word(k);
      end
    end else begin
      if (!bus0.sram_ce_n && !bus0.sram_we_n && bus0.sram_dq_oe)
        for (int k = 0; k < 4; k++)
          if (!bus0.sram_be_n[k]) mem0[bus0.sram_addr[7:0]][8*k +: 8] <= bus0.sram_dq_o[8*k +: 8];
      if (!bus1.sram_ce_n && !bus1.sram_we_n && bus1.sram_dq_oe)
        for (int k = 0; k < 4; k++)
          if (!bus1.sram_be_n[k]) mem1[bus1.sram_addr[7:0]][8*k +: 8] <= bus1.sram_dq_o[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [1:0] b, input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  by;
    logic [15:0] hw;
    sh = w >> (8 * b);
    by = sh[7:0];
    hw = b[1] ? w[31:16] : w[15:0];
    case (op)
      MEM_LB:  return by[7] ? 32'(by) - 32'd256 : 32'(by);
      MEM_LBU: return 32'(by);
      MEM_LH:  return hw[15] ? 32'(hw) - 32'h10000 : 32'(hw);
      MEM_LHU: return 32'(hw);
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [1:0] b);
    case (op)
      MEM_SB:  return 4'(15 - (1 << b));
      MEM_SH:  return b[1] ? 4'b0011 : 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] m_dq(input logic [3:0] op, input logic [31:0] w);
    case (op)
      MEM_SB:  return 32'(w[7:0]) * 32'h01010101;
      MEM_SH:  return 32'(w[15:0]) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  // Issued from an idle negedge; leaves the arbiter idle on return.
  task automatic data_txn(input logic [3:0] op, input logic [7:0] a, input logic [1:0] b,
                          input logic [31:0] wd, input int lat);
    int n, we_cnt, oe_cnt, stall_bad;
    logic got, st;
    logic [3:0]  be_seen;
    logic [31:0] dq_seen, exp;
    st = (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    bus0.data_op = op; bus0.data_addr = AW'(a); bus0.data_bytes = b; bus0.data_wdata = wd;
    n = 0; we_cnt = 0; oe_cnt = 0; stall_bad = 0; got = 1'b0; be_seen = 4'hF; dq_seen = '0;
    while (!got && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
      if (!bus0.sram_we_n) begin we_cnt++; be_seen = bus0.sram_be_n; dq_seen = bus0.sram_dq_o; end
      if (!bus0.sram_oe_n) oe_cnt++;
      if (bus0.data_done) got = 1'b1;
      else if (!bus0.data_stall) stall_bad++;
    end
    chk("data_done_seen", 32'(got), 32'd1);
    chk("data_latency", n, lat);
    chk("data_stall_wait", stall_bad, 0);
    if (st) begin
      chk("we_low_cycles", we_cnt, WE0);
      chk("store_be_n", 32'(be_seen), 32'(m_be(op, b)));
      chk("store_dq_o", dq_seen, m_dq(op, wd));
      for (int k = 0; k < 4; k++)
        if (!m_be(op, b)[k]) ref0[a][8*k +: 8] = m_dq(op, wd)[8*k +: 8];
    end else begin
      exp = m_load(op, b, ref0[a]);
      chk("load_rdata", bus0.data_rdata, exp);
      chk("oe_low_cycles", oe_cnt, RW0 + 1);
    end
    $display("txn dut0 data op=%0d addr=%02h bytes=%0d wdata=%08h latency=%0d rdata=%08h",
             op, a, b, wd, n, bus0.data_rdata);
    bus0.data_op = MEM_NOP;
    @(negedge clk);
  endtask

  task automatic fetch_txn(input logic [7:0] a, input int lat);
    int n, oe_cnt, stall_bad;
    logic got;
    bus0.inst_req = 1'b1; bus0.inst_addr = AW'(a);
    n = 0; oe_cnt = 0; stall_bad = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
      if (!bus0.sram_oe_n) oe_cnt++;
      if (bus0.inst_done) got = 1'b1;
      else if (!bus0.inst_stall) stall_bad++;
    end
    chk("inst_done_seen", 32'(got), 32'd1);
    chk("inst_latency", n, lat);
    chk("inst_stall_wait", stall_bad, 0);
    chk("inst_rdata", bus0.inst_rdata, ref0[a]);
    chk("inst_oe_cycles", oe_cnt, RW0 + 1);
    $display("txn dut0 fetch addr=%02h latency=%0d rdata=%08h", a, n, bus0.inst_rdata);
    bus0.inst_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait1(output int n, output int we_cnt);
    logic got;
    n = 0; we_cnt = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
      if (!bus1.sram_we_n) we_cnt++;
      if (bus1.inst_done || bus1.data_done) got = 1'b1;
    end
    chk("dut1_done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    byte exp_ord [6];
    byte got_ord [6];
    int n, cyc, last, ng, stall_bad, bad, cnt, we_cnt;
    logic [7:0]  ia, da, a;
    logic [3:0]  op;
    logic [31:0] wd;

    rst = 1'b0; mem_init = 1'b1;
    bus0.inst_req = 1'b0; bus0.inst_addr = '0; bus0.data_op = MEM_NOP;
    bus0.data_addr = '0; bus0.data_bytes = '0; bus0.data_wdata = '0;
    bus1.inst_req = 1'b0; bus1.inst_addr = '0; bus1.data_op = MEM_NOP;
    bus1.data_addr = '0; bus1.data_bytes = '0; bus1.data_wdata = '0;
    for (int k = 0; k < 256; k++) ref0[k] = init_word(k);

    repeat (3) @(negedge clk);
    chk("rst_ce_n", 32'(bus0.sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(bus0.sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(bus0.sram_we_n), 32'd1);
    chk("rst_be_n", 32'(bus0.sram_be_n), 32'hF);
    chk("rst_dq_oe", 32'(bus0.sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(bus0.sram_addr), 32'd0);
    chk("rst_dq_o", bus0.sram_dq_o, 32'd0);
    chk("rst_rdata", bus0.inst_rdata | bus0.data_rdata, 32'd0);
    chk("rst_done", 32'({bus0.inst_done, bus0.data_done}), 32'd0);
    mem_init = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Directed accesses.
    fetch_txn(8'h10, RW0 + 2);
    data_txn(MEM_SB, 8'h20, 2'd2, 32'h000000AB, WE0 + 3);
    data_txn(MEM_LB,  8'h30, 2'd3, 32'h0, RW0 + 2);
    data_txn(MEM_LBU, 8'h30, 2'd3, 32'h0, RW0 + 2);
    data_txn(MEM_LHU, 8'h30, 2'd2, 32'h0, RW0 + 2);
    data_txn(MEM_LH,  8'h30, 2'd2, 32'h0, RW0 + 2);
    data_txn(MEM_LW,  8'h20, 2'd1, 32'h0, RW0 + 2);
    data_txn(MEM_SH,  8'h21, 2'd3, 32'hCAFE1357, WE0 + 3);
    data_txn(MEM_LW,  8'h21, 2'd0, 32'h0, RW0 + 2);

    // Continuous contention: expected order from the starvation rule.
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (cnt == 2) begin exp_ord[i] = "I"; cnt = 0; end
      else begin exp_ord[i] = "D"; cnt++; end
      got_ord[i] = "?";
    end
    ia = 8'($urandom_range(0, 31)); da = 8'($urandom_range(0, 31));
    bus0.inst_req = 1'b1; bus0.inst_addr = AW'(ia);
    bus0.data_op = MEM_LW; bus0.data_addr = AW'(da); bus0.data_bytes = 2'd0;
    ng = 0; cyc = 0; last = 0; stall_bad = 0;
    while (ng < 6 && cyc < 100) begin
      @(posedge clk); cyc++; @(negedge clk);
      if (!bus0.inst_done && !bus0.inst_stall) stall_bad++;
      if (bus0.inst_done || bus0.data_done) begin
        if (ng > 0) chk("arb_gap", cyc - last, RW0 + 3);
        last = cyc;
        if (bus0.inst_done) begin
          got_ord[ng] = "I";
          chk("arb_inst_rdata", bus0.inst_rdata, ref0[ia]);
          ia = 8'($urandom_range(0, 31)); bus0.inst_addr = AW'(ia);
        end else begin
          got_ord[ng] = "D";
          chk("arb_data_rdata", bus0.data_rdata, ref0[da]);
          da = 8'($urandom_range(0, 31)); bus0.data_addr = AW'(da);
        end
        $display("txn dut0 contention grant=%0d port=%c cycle=%0d", ng, got_ord[ng], cyc);
        ng++;
      end
    end
    chk("arb_count", ng, 6);
    chk("arb_inst_stall", stall_bad, 0);
    for (int i = 0; i < 6; i++) chk("arb_order", 32'(got_ord[i]), 32'(exp_ord[i]));
    bus0.inst_req = 1'b0; bus0.data_op = MEM_NOP;
    @(negedge clk);

    // Request withdrawn after the grant still completes.
    bus0.data_op = MEM_LW; bus0.data_addr = AW'(8'h10);
    @(posedge clk); @(negedge clk);
    bus0.data_op = MEM_NOP;
    n = 1; cyc = 0;
    while (!bus0.data_done && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    chk("withdraw_latency", n, RW0 + 2);
    chk("withdraw_rdata", bus0.data_rdata, ref0[8'h10]);
    $display("txn dut0 withdrawn load latency=%0d rdata=%08h", n, bus0.data_rdata);
    @(negedge clk);

    // Unknown op code behaves as no request.
    bus0.data_op = 4'hC; bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (!bus0.sram_ce_n || bus0.data_done || bus0.data_stall) bad++;
    end
    chk("unknown_op_idle", bad, 0);
    $display("txn dut0 unknown op=0xC idle_violations=%0d", bad);
    bus0.data_op = MEM_NOP;
    @(negedge clk);

    // Randomized mix against the reference memory.
    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(0, 8);
      a = 8'($urandom_range(0, 31));
      wd = $urandom;
      if (n == 0) fetch_txn(a, RW0 + 2);
      else begin
        op = 4'(n);
        data_txn(op, a, 2'($urandom_range(0, 3)), wd,
                 (op == MEM_SW || op == MEM_SH || op == MEM_SB) ? WE0 + 3 : RW0 + 2);
      end
    end

    // Reset during the write pulse aborts at once.
    bus0.data_op = MEM_SW; bus0.data_addr = AW'(8'hF0); bus0.data_wdata = 32'h12345678;
    n = 0;
    while (bus0.sram_we_n && n < 10) begin @(posedge clk); n++; @(negedge clk); end
    chk("abort_reached_pulse", 32'(bus0.sram_we_n), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_we_n", 32'(bus0.sram_we_n), 32'd1);
    chk("abort_dq_oe", 32'(bus0.sram_dq_oe), 32'd0);
    chk("abort_be_n", 32'(bus0.sram_be_n), 32'hF);
    chk("abort_ce_n", 32'(bus0.sram_ce_n), 32'd1);
    bus0.data_op = MEM_NOP;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; bad = 0;
    repeat (6) begin @(negedge clk); if (bus0.data_done || !bus0.sram_ce_n) bad++; end
    chk("abort_no_done", bad, 0);
    $display("txn dut0 reset-abort store violations=%0d", bad);
    fetch_txn(8'h10, RW0 + 2);

    // Fast build: shorter latencies and a single idle cycle between accesses.
    bus1.inst_req = 1'b1; bus1.inst_addr = AW'(8'h05);
    wait1(n, we_cnt);
    chk("dut1_read_latency", n, RW1 + 2);
    chk("dut1_inst_rdata", bus1.inst_rdata, init_word(5));
    $display("txn dut1 fetch addr=05 latency=%0d rdata=%08h", n, bus1.inst_rdata);
    bus1.inst_req = 1'b0;
    @(negedge clk);
    wd = $urandom;
    bus1.data_op = MEM_SW; bus1.data_addr = AW'(8'h09); bus1.data_wdata = wd;
    wait1(n, we_cnt);
    chk("dut1_write_latency", n, WE1 + 3);
    chk("dut1_we_cycles", we_cnt, WE1);
    $display("txn dut1 store addr=09 wdata=%08h latency=%0d", wd, n);
    bus1.data_op = MEM_NOP;
    @(negedge clk);
    bus1.data_op = MEM_LW;
    wait1(n, we_cnt);
    chk("dut1_load_latency", n, RW1 + 2);
    chk("dut1_load_rdata", bus1.data_rdata, wd);
    $display("txn dut1 load addr=09 latency=%0d rdata=%08h", n, bus1.data_rdata);
    for (int i = 0; i < 2; i++) begin
      wait1(n, we_cnt);
      chk("dut1_b2b_gap", n, RW1 + 3);
      chk("dut1_b2b_rdata", bus1.data_rdata, wd);
      $display("txn dut1 back-to-back load gap=%0d rdata=%08h", n, bus1.data_rdata);
    end
    bus1.data_op = MEM_NOP;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
